// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step tick sequencer for the core: debounced buttons, programmable
// tick divider, one-cycle cpu_tick enable pulses and a tick counter.
module cpu_clock_ctrl #(
  parameter int                   DIV_WIDTH   = 28,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 28'd500000,
  parameter int                   DB_CYCLES   = 250000,
  parameter int                   DB_WIDTH    = 20
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 run_btn,
  input  logic                 step_btn,
  input  logic                 halt_req,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 cpu_tick,
  output logic [1:0]           state,
  output logic                 slow_clock,
  output logic [31:0]          tick_count
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_t;

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);

  // Bit 0 is the run button, bit 1 the step button.
  logic [1:0]               w_btn;
  logic [1:0]               r_sync1, r_sync2, r_level, r_press;
  logic [1:0][DB_WIDTH-1:0] r_db_cnt;

  state_t                   r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]     r_div, w_div_nxt;
  logic [DIV_WIDTH-1:0]     r_cnt, w_cnt_nxt;
  logic                     r_tick, w_tick_nxt;
  logic                     r_slow, w_slow_nxt;
  logic [31:0]              r_tick_count;
  logic                     w_run_press, w_step_press;

  assign w_btn        = {step_btn, run_btn};
  assign w_run_press  = r_press[0];
  assign w_step_press = r_press[1];

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_level  <= '0;
      r_press  <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          // Only an accepted rising level counts as a press.
          r_level[i]  <= r_sync2[i];
          r_db_cnt[i] <= '0;
          r_press[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    w_div_nxt   = r_div;
    if (div_load) begin
      w_div_nxt = (div_value == '0) ? DIV_WIDTH'(1) : div_value;
    end
    unique case (r_state)
      S_HALT: begin
        if (!halt_req) begin
          if (w_run_press) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else if (w_step_press) begin
            w_state_nxt = S_STEP;
            w_tick_nxt  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (halt_req || w_run_press) begin
          w_state_nxt = S_HALT;
          w_cnt_nxt   = '0;
        end else if (div_load) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == r_div - DIV_WIDTH'(1)) begin
          w_cnt_nxt  = '0;
          w_tick_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DIV_WIDTH'(1);
        end
      end
      S_STEP:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_HALT;
    endcase
    if (div_load) begin
      w_cnt_nxt = '0;
    end
    // Registered from next-state values so slow_clock tracks the current cnt.
    w_slow_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt < (w_div_nxt >> 1));
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_state      <= S_HALT;
      r_div        <= DEFAULT_DIV;
      r_cnt        <= '0;
      r_tick       <= 1'b0;
      r_slow       <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tick       <= w_tick_nxt;
      r_slow       <= w_slow_nxt;
      r_tick_count <= r_tick_count + {31'd0, r_tick};
    end
  end

  assign cpu_tick   = r_tick;
  assign state      = r_state;
  assign slow_clock = r_slow;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed + randomized checks of cpu_clock_ctrl against a cycle-level behavioural model.
module tb_cpu_clock_ctrl;
  localparam int DW = 28;
  localparam int DB = 4;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2;

  logic          clock_in = 1'b0;
  logic          reset = 1'b1;
  logic          run_btn = 1'b0, step_btn = 1'b0, halt_req = 1'b0, div_load = 1'b0;
  logic [DW-1:0] div_value = '0;
  logic          cpu_tick;
  logic [1:0]    state;
  logic          slow_clock;
  logic [31:0]   tick_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clock_in = ~clock_in;

  cpu_clock_ctrl #(
    .DIV_WIDTH  (DW),
    .DEFAULT_DIV(28'd5),
    .DB_CYCLES  (DB),
    .DB_WIDTH   (20)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .run_btn   (run_btn),
    .step_btn  (step_btn),
    .halt_req  (halt_req),
    .div_load  (div_load),
    .div_value (div_value),
    .cpu_tick  (cpu_tick),
    .state     (state),
    .slow_clock(slow_clock),
    .tick_count(tick_count)
  );

  // Reference model: mode, phase within the divided period, and per-button
  // 2-sample delay line plus a count of consecutive samples disagreeing with the accepted level.
  int          m_st, m_phase, m_div;
  bit          m_tick, m_slow;
  logic [31:0] m_count;
  bit          m_d1[2], m_d2[2], m_lvl[2], m_pr[2];
  int          m_diff[2];

  task automatic model_reset();
    m_st = M_HALT; m_phase = 0; m_div = 5; m_tick = 0; m_slow = 0; m_count = '0;
    for (int b = 0; b < 2; b++) begin
      m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_pr[b] = 0; m_diff[b] = 0;
    end
  endtask

  task automatic model_edge();
    int nst, nph, ndiv;
    bit ntick, np;
    bit raw[2];
    raw[0] = run_btn; raw[1] = step_btn;
    nst = m_st; nph = m_phase; ndiv = m_div; ntick = 0;
    if (div_load) ndiv = (div_value == 0) ? 1 : int'(div_value);
    if (m_st == M_HALT) begin
      if (!halt_req && m_pr[0]) begin nst = M_RUN; nph = 0; end
      else if (!halt_req && m_pr[1]) begin nst = M_STEP; ntick = 1; end
    end else if (m_st == M_RUN) begin
      if (halt_req || m_pr[0]) begin nst = M_HALT; nph = 0; end
      else if (!div_load) begin
        nph = (m_phase + 1) % m_div;
        ntick = (nph == 0);
      end
    end else begin
      nst = M_HALT;
    end
    if (div_load) nph = 0;
    m_count = m_count + 32'(m_tick);
    m_st = nst; m_phase = nph; m_div = ndiv; m_tick = ntick;
    m_slow = (nst == M_RUN) && (nph < ndiv / 2);
    for (int b = 0; b < 2; b++) begin
      np = 0;
      if (m_d2[b] == m_lvl[b]) m_diff[b] = 0;
      else begin
        m_diff[b] = m_diff[b] + 1;
        if (m_diff[b] == DB) begin
          m_lvl[b] = m_d2[b]; m_diff[b] = 0; np = m_lvl[b];
        end
      end
      m_pr[b] = np;
      m_d2[b] = m_d1[b];
      m_d1[b] = raw[b];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_in);
    model_edge();
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("cpu_tick", 32'(cpu_tick), 32'(m_tick));
    chk("slow_clock", 32'(slow_clock), 32'(m_slow));
    chk("tick_count", tick_count, m_count);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int nt, last, found;
    int hold[2];
    logic [31:0] base;
    model_reset();
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_tick", 32'(cpu_tick), 0);
    chk("rst_count", tick_count, 0);
    chk("rst_slow", 32'(slow_clock), 0);
    repeat (2) @(posedge clock_in);
    #1 reset = 1'b0;
    cyc();

    // Debounce: short bounce ignored, held press enters RUN on the 7th edge
    run_btn = 1; cycles(3); run_btn = 0; cycles(10);
    chk("bounce_state", 32'(state), M_HALT);
    run_btn = 1; cycles(6);
    chk("db_before", 32'(state), M_HALT);
    cyc();
    chk("db_run", 32'(state), M_RUN);
    cycles(3); run_btn = 0; cycles(8);

    // Run rate with divisor 5
    nt = 0; last = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (cpu_tick) begin
        if (last >= 0) chk("tick_gap", 32'(i - last), 5);
        last = i; nt++;
      end
    end
    chk("ticks_in_40", 32'(nt), 8);

    // Divisor 0 becomes 1: tick every cycle from the second cycle after load
    div_value = '0; div_load = 1; cyc(); div_load = 0;
    chk("load_no_tick", 32'(cpu_tick), 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("div1_tick", 32'(cpu_tick), 1);
    end
    run_btn = 1; cycles(7); run_btn = 0;
    chk("halt_by_btn", 32'(state), M_HALT);
    cycles(8);
    div_value = DW'(5); div_load = 1; cyc(); div_load = 0;

    // Single steps in HALT
    base = m_count;
    for (int k = 0; k < 3; k++) begin
      step_btn = 1; cycles(6);
      cyc();
      chk("step_state", 32'(state), M_STEP);
      chk("step_tick", 32'(cpu_tick), 1);
      cyc();
      chk("step_back", 32'(state), M_HALT);
      chk("step_tick_end", 32'(cpu_tick), 0);
      step_btn = 0; cycles(8);
    end
    chk("step_count", tick_count, base + 3);

    // Step button ignored in RUN
    run_btn = 1; cycles(7); run_btn = 0; cycles(8);
    nt = 0;
    step_btn = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) step_btn = 0;
      cyc();
      if (cpu_tick) nt++;
    end
    chk("run_step_ticks", 32'(nt), 4);
    chk("run_step_state", 32'(state), M_RUN);

    // halt_req on the cycle a tick is due
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc();
      if (m_phase == 4) found = 1;
    end
    chk("phase4_found", 32'(found), 1);
    halt_req = 1; cyc();
    chk("halt_req_tick", 32'(cpu_tick), 0);
    chk("halt_req_state", 32'(state), M_HALT);
    run_btn = 1; cycles(7); run_btn = 0; cycles(8);
    chk("halt_req_hold", 32'(state), M_HALT);
    halt_req = 0; cyc();

    // tick_count wrap
    force dut.r_tick_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    cycles(2);
    release dut.r_tick_count;
    step_btn = 1; cycles(7); step_btn = 0; cyc();
    chk("wrap_count", tick_count, 0);
    cycles(8);

    // Randomized inputs
    hold[0] = 3; hold[1] = 7;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 2; b++) begin
        if (hold[b] == 0) begin
          if (b == 0) run_btn = ~run_btn; else step_btn = ~step_btn;
          hold[b] = $urandom_range(1, 10);
        end else hold[b]--;
      end
      halt_req  = ($urandom_range(0, 19) == 0);
      div_load  = ($urandom_range(0, 29) == 0);
      div_value = DW'($urandom_range(0, 7));
      cyc();
    end
    run_btn = 0; step_btn = 0; halt_req = 0; div_load = 0;
    cycles(12);

    // Asynchronous reset while cpu_tick is high in RUN
    div_value = DW'(1); div_load = 1; cyc(); div_load = 0;
    if (m_st != M_RUN) begin
      run_btn = 1; cycles(7); run_btn = 0;
    end
    cycles(8);
    chk("pre_reset_tick", 32'(cpu_tick), 1);
    #3 reset = 1;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_tick", 32'(cpu_tick), 0);
    chk("async_count", tick_count, 0);
    chk("async_slow", 32'(slow_clock), 0);
    @(negedge clock_in);
    reset = 0;
    model_reset();
    chk("div_after_reset", 32'(dut.r_div), 5);
    run_btn = 1; cycles(7); run_btn = 0;
    cycles(4);
    chk("first_tick_wait", 32'(cpu_tick), 0);
    cyc();
    chk("first_tick", 32'(cpu_tick), 1);
    cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Run/halt/single-step sequencer for the non-pipelined RISC-V core on the FPGA board. Replaces free-running use of a divided clock: the core stays on the board clock `clock_in` and advances only on a one-cycle enable pulse, `cpu_tick`, issued by this block. Pulses are produced at a programmable divided rate in RUN, one per button press in single-step mode, and never while halted. The block debounces the board buttons and counts issued ticks for the debug display.

## Interface
- `DIV_WIDTH`, 28: width of the divisor and the divide counter.
- `DEFAULT_DIV`, 28'd500000: divisor loaded at reset.
- `DB_CYCLES`, 250000: number of consecutive stable cycles required to accept a button level change.
- `DB_WIDTH`, 20: width of each debounce counter. Must satisfy 2^DB_WIDTH > DB_CYCLES.
- `clock_in`  in  1  board clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run_btn`  in  1  raw asynchronous button; a press toggles RUN/HALT.
- `step_btn`  in  1  raw asynchronous button; a press in HALT issues exactly one tick.
- `halt_req`  in  1  synchronous level from the core (ebreak/trap); forces HALT.
- `div_load`  in  1  synchronous one-cycle strobe; loads `div_value`.
- `div_value`  in  DIV_WIDTH  new divisor.
- `cpu_tick`  out  1  registered enable for the core; high for exactly one `clock_in` cycle per tick.
- `state`  out  2  current state: 00 HALT, 01 RUN, 10 STEP.
- `slow_clock`  out  1  registered ~50% square wave at the tick rate, for an LED.
- `tick_count`  out  32  number of ticks issued since reset.

## Operation
- **Reset values:** `state` = HALT, `cpu_tick` = 0, `slow_clock` = 0, `tick_count` = 0, `div_reg` = DEFAULT_DIV, `cnt` = 0, all synchronizer and debounce flops = 0 (button released).
- **Button conditioning** (each button independent):
  - 2-flop synchronizer.
  - A debounce counter clears whenever the synchronized level equals the accepted level; otherwise it increments.
  - When the counter reaches DB_CYCLES-1, the accepted level flips and the counter clears.
  - An accepted 0→1 transition produces a one-cycle `run_press` or `step_press`. Release produces nothing.
- **Divisor:**
  - On `div_load`, `div_reg` takes `div_value`, or 1 if `div_value` is 0.
  - `cnt` clears on the same edge.
  - No tick is issued on the load cycle.
- **State machine** (priority order within each state):
  - HALT:
    - `halt_req` → stay in HALT.
    - `run_press` → RUN, with `cnt` cleared.
    - `step_press` → STEP.
    - Otherwise stay.
  - RUN:
    - `halt_req` or `run_press` → HALT, with `cnt` cleared.
    - `step_press` is ignored.
  - STEP: always → HALT after one cycle, regardless of any input.
- **Tick generation:**
  - `cpu_tick` is set on the edge that enters STEP, so it is high during the single STEP cycle.
  - In RUN, `cnt` increments each cycle. When `cnt == div_reg-1` and no `div_load`, `halt_req` or `run_press` is present, `cnt` wraps to 0 and `cpu_tick` is set for the next cycle.
  - In all other cases `cpu_tick` is 0.
- **slow_clock:**
  - In RUN, `slow_clock` is 1 while `cnt < div_reg/2` and 0 otherwise.
  - In HALT and STEP, `slow_clock` is 0.
- **tick_count:** increments by 1 on every cycle in which `cpu_tick` = 1. It wraps modulo 2^32 (0xFFFFFFFF → 0).

## Timing
- **Press latency:** a raw button edge held stable produces the press pulse 2 + DB_CYCLES cycles later. A bounce that returns before DB_CYCLES stable cycles produces no pulse.
- **Step latency:** the cycle after `step_press`, `state` = STEP and `cpu_tick` = 1. One cycle later, `state` = HALT and `cpu_tick` = 0. Exactly one tick is issued per press.
- **Run rate:** the first tick is high `div_reg` cycles after the RUN entry edge. Ticks then repeat every `div_reg` cycles. With `div_reg` = 1, `cpu_tick` is continuously high while in RUN.
- **halt_req effects:** takes effect on the next edge. A tick pending on that same edge is suppressed. The core sees no tick after the cycle in which it raised `halt_req`.
- **Reset mid-operation:** asynchronous assertion immediately forces all outputs to their reset values, including dropping a high `cpu_tick` within the cycle.

## Test plan
Parameters for all scenarios: DB_CYCLES = 4, DEFAULT_DIV = 5.

1. **Reset:** assert `reset` mid-RUN, between edges → `cpu_tick`, `state`, `tick_count` and `slow_clock` are all 0 immediately, and `div_reg` = 5 after release.
2. **Debounce:** pulse `run_btn` high for 3 cycles → no state change. Hold it high for 10 cycles → `state` = RUN exactly 2+4+1 cycles after the rising edge.
3. **Run rate:** in RUN with `div_reg` = 5, observe 40 cycles → `cpu_tick` is high exactly 8 times, spaced 5 cycles apart, and `tick_count` = 8. Load `div_value` = 0 → `cpu_tick` is high every cycle from the second cycle after the load.
4. **Single step:** in HALT, make 3 `step_btn` presses → 3 one-cycle `cpu_tick` pulses, `state` sequence HALT→STEP→HALT for each, and `tick_count` = 3. A `step_btn` press in RUN → no extra tick.
5. **halt_req priority:** raise `halt_req` on the cycle where `cnt` = 4 in RUN → no tick, and `state` = HALT next cycle. Press `run_btn` while `halt_req` = 1 → remains in HALT.
6. **Counter wrap:** force `tick_count` to 0xFFFFFFFF, then issue one step → `tick_count` = 0.
